storage_summary_printer: RTL and testbench
==========================================

Name: storage_summary_printer

Overview:
- Display-mode output stage. Sits between matrix storage (info table, total count) and the shared uart_tx.
- On start, snapshots the storage summary and streams it as ASCII text to the UART transmitter. It uses the same tx_start/tx_busy handshake as the matrix printers.
- Top level drives uart_tx from this block while display_mode_en is high.

Parameters:
- MAX_DIM, 5, maximum matrix rows and columns; size classes = MAX_DIM*MAX_DIM.
- CNT_WIDTH, 2, bits per size-class count in info_table.
- TOTAL_WIDTH, 6, width of total_count; values must be ≤ 99.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to print the summary; ignored while busy.
- abort  input  1  mode exit; cancels printing.
- total_count  input  TOTAL_WIDTH  number of stored matrices.
- info_table  input  MAX_DIM*MAX_DIM*CNT_WIDTH  per-size counts. Index idx = (m-1)*MAX_DIM + (n-1); count sits in bits [idx*CNT_WIDTH +: CNT_WIDTH].
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  8  ASCII byte to send.
- tx_busy  input  1  uart_tx busy flag.
- busy  output  1  high from start acceptance until done or abort.
- done  output  1  one-cycle pulse after the last byte has completed.

Behaviour:
- Reset values: tx_start=0, tx_data=0, busy=0, done=0, state=IDLE, all snapshot registers 0.
- Output byte stream, in order:
  - Header line: 'T'(0x54), '='(0x3D), tens digit ('0'+total/10) only if total ≥ 10, ones digit ('0'+total%10), CR(0x0D), LF(0x0A).
  - For each idx from 0 up to MAX_DIM²-1 with a nonzero count: '0'+m, '*'(0x2A), '0'+n, '*', '0'+count, CR, LF.
  - Size classes with a zero count emit nothing.
- No consistency check between total_count and the table sum; both are printed as given.
- States: IDLE, LOAD, HDR, SCAN, ENTRY, SEND, WAIT_ACK, WAIT_DONE, FINISH.
  - IDLE: on start, go to LOAD; busy goes high in the next cycle.
  - LOAD: register total_count and info_table. Precompute tens and ones digits by compare/subtract, no divider. Go to HDR.
  - HDR / ENTRY: the character sequencer picks the next byte, latches it into tx_data, and goes to SEND.
  - SCAN: tests one idx per cycle. A nonzero count goes to ENTRY; otherwise idx increments. Past the last idx, go to FINISH.
  - SEND: if tx_busy=0, assert tx_start for exactly one cycle and go to WAIT_ACK. Otherwise hold.
  - WAIT_ACK: wait until tx_busy=1.
  - WAIT_DONE: wait until tx_busy=0, then return to the sequencer. After the header or an entry completes, go to SCAN.
  - FINISH: pulse done for one cycle, clear busy, go to IDLE.
- tx_data is stable from the tx_start cycle until the next byte is selected.
- At most one tx_start per byte. No tx_start is issued while tx_busy=1.
- First tx_start occurs ≤ 4 cycles after start when tx_busy=0.
- Snapshot rule: changes on info_table or total_count after LOAD do not affect the current output.
- start while busy: ignored, with no restart and no effect on the stream.
- abort has priority over every state, including start in the same cycle. Next cycle: state=IDLE, busy=0, tx_start=0, no done pulse. The byte already handed to uart_tx is not recalled.
- start and abort in the same cycle while idle: start is ignored.
- Asynchronous reset mid-stream: all outputs return to their reset values immediately.
- Digit width rule: each count is zero-extended to 8 bits before adding 0x30. m and n come from idx/MAX_DIM and idx%MAX_DIM using counters, not a divider: keep m and n row/column counters alongside idx.

Test Plan:
- Empty storage: total=0, table all zero, start, uart model 10-cycle busy → bytes 54 3D 30 0D 0A, then a single done pulse, busy low.
- Single 2x3 matrix count 2 (idx 7, bits[15:14]=2'b10), total=2 → "T=2\r\n2*3*2\r\n", 12 bytes, done once.
- Corners: idx0 count 1, idx24 count 3, total=4 → "T=4\r\n1*1*1\r\n5*5*3\r\n".
- Two-digit total: total=12 with arbitrary table → header 54 3D 31 32 0D 0A.
- Handshake stress: tx_busy rises 2 cycles after each tx_start and stays high 100 cycles → exactly one tx_start per byte, none while busy, and the byte stream is unchanged.
- Abort/robustness:
  - Assert abort after the 3rd byte → busy=0 next cycle, no further tx_start, no done. A new start then yields the full stream.
  - Change info_table mid-print → output matches the original snapshot.
  - A second start mid-print is ignored.

Source files
------------

// File: rtl/storage_summary_printer_if.sv
// Byte handshake between a printer and the shared uart_tx:
// a one-cycle tx_start hands tx_data over; tx_busy is high while the UART is sending.
interface storage_summary_printer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/storage_summary_printer.sv
// Snapshots the storage summary (total count and per-size counts) and streams it
// to uart_tx as "T=<total>\r\n" followed by one "m*n*count\r\n" line per non-empty size class.
//
// UART handshake: in SEND the byte is offered by a one-cycle tx_start, and only when tx_busy
// is low. The block then waits for tx_busy to rise (accepted) and fall (sent) before it
// selects the next byte.
module storage_summary_printer #(
  parameter int MAX_DIM     = 5,
  parameter int CNT_WIDTH   = 2,
  parameter int TOTAL_WIDTH = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [TOTAL_WIDTH-1:0]               total_count,
  input  logic [MAX_DIM*MAX_DIM*CNT_WIDTH-1:0] info_table,
  storage_summary_printer_if.master            uart,
  output logic                                 busy,
  output logic                                 done,
  output logic [3:0]                           dbg_state
);

  localparam int NUM   = MAX_DIM * MAX_DIM;
  localparam int TBL_W = NUM * CNT_WIDTH;
  localparam int IDX_W = $clog2(NUM + 1);
  localparam int DIM_W = $clog2(MAX_DIM + 2);

  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_0    = 8'h30;

  typedef enum logic [3:0] {
    IDLE, LOAD, HDR, SCAN, ENTRY, SEND, WAIT_ACK, WAIT_DONE, FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [TBL_W-1:0]     table_q, table_d;
  logic [3:0]           tens_q, tens_d;
  logic [3:0]           ones_q, ones_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DIM_W-1:0]     m_q, m_d;
  logic [DIM_W-1:0]     n_q, n_d;
  logic [2:0]           char_q, char_d;
  logic                 hdr_q, hdr_d;
  logic                 last_q, last_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [7:0]           total_ext;
  logic [3:0]           tens_calc;
  logic [3:0]           ones_calc;
  logic [CNT_WIDTH-1:0] cur_cnt;

  // Decimal split of the total by repeated compare against multiples of ten.
  always_comb begin
    total_ext = 8'(total_count);
    tens_calc = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (total_ext >= 8'(k * 10)) tens_calc = 4'(k);
    end
    ones_calc = 4'(total_ext - 8'(tens_calc) * 8'd10);
  end

  assign cur_cnt = CNT_WIDTH'(table_q >> (idx_q * CNT_WIDTH));

  always_comb begin
    state_d    = state_q;
    table_d    = table_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    idx_d      = idx_q;
    m_d        = m_q;
    n_d        = n_q;
    char_d     = char_q;
    hdr_d      = hdr_q;
    last_d     = last_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        table_d = info_table;
        tens_d  = tens_calc;
        ones_d  = ones_calc;
        idx_d   = '0;
        m_d     = DIM_W'(1);
        n_d     = DIM_W'(1);
        char_d  = 3'd0;
        hdr_d   = 1'b1;
        last_d  = 1'b0;
        state_d = HDR;
      end
      HDR: begin
        state_d = SEND;
        case (char_q)
          3'd0: begin tx_data_d = CH_T;  char_d = 3'd1; end
          3'd1: begin tx_data_d = CH_EQ; char_d = (tens_q != 4'd0) ? 3'd2 : 3'd3; end
          3'd2: begin tx_data_d = CH_0 + 8'(tens_q); char_d = 3'd3; end
          3'd3: begin tx_data_d = CH_0 + 8'(ones_q); char_d = 3'd4; end
          3'd4: begin tx_data_d = CH_CR; char_d = 3'd5; end
          default: begin tx_data_d = CH_LF; last_d = 1'b1; end
        endcase
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM)) begin
          state_d = FINISH;
        end else if (cur_cnt != '0) begin
          state_d = ENTRY;
          hdr_d   = 1'b0;
          char_d  = 3'd0;
          last_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
          if (n_q == DIM_W'(MAX_DIM)) begin
            n_d = DIM_W'(1);
            m_d = m_q + 1'b1;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      ENTRY: begin
        state_d = SEND;
        case (char_q)
          3'd0: begin tx_data_d = CH_0 + 8'(m_q);    char_d = 3'd1; end
          3'd1: begin tx_data_d = CH_STAR;           char_d = 3'd2; end
          3'd2: begin tx_data_d = CH_0 + 8'(n_q);    char_d = 3'd3; end
          3'd3: begin tx_data_d = CH_STAR;           char_d = 3'd4; end
          3'd4: begin tx_data_d = CH_0 + 8'(cur_cnt); char_d = 3'd5; end
          3'd5: begin tx_data_d = CH_CR;             char_d = 3'd6; end
          default: begin tx_data_d = CH_LF; last_d = 1'b1; end
        endcase
      end
      SEND: begin
        if (!uart.tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (uart.tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!uart.tx_busy) begin
          if (last_q) begin
            // A finished entry line moves the scan past its size class.
            last_d  = 1'b0;
            char_d  = 3'd0;
            state_d = SCAN;
            if (!hdr_q) begin
              idx_d = idx_q + 1'b1;
              if (n_q == DIM_W'(MAX_DIM)) begin
                n_d = DIM_W'(1);
                m_d = m_q + 1'b1;
              end else begin
                n_d = n_q + 1'b1;
              end
            end
          end else begin
            state_d = hdr_q ? HDR : ENTRY;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      tx_start_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      table_q    <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      idx_q      <= '0;
      m_q        <= '0;
      n_q        <= '0;
      char_q     <= '0;
      hdr_q      <= 1'b0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      idx_q      <= idx_d;
      m_q        <= m_d;
      n_q        <= n_d;
      char_q     <= char_d;
      hdr_q      <= hdr_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uart.tx_start = tx_start_q;
  assign uart.tx_data  = tx_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_storage_summary_printer.sv
// Directed bench for storage_summary_printer: a table of summaries with hand-written
// expected text, plus sequences for abort, snapshot, restart, start/abort clash and async reset.
module tb_storage_summary_printer;

  localparam int TBL_W = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [5:0]       total_count = '0;
  logic [TBL_W-1:0] info_table = '0;
  logic             busy;
  logic             done;
  logic [3:0]       dbg_state;

  storage_summary_printer_if u_if ();

  storage_summary_printer #(
    .MAX_DIM(5), .CNT_WIDTH(2), .TOTAL_WIDTH(6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .total_count(total_count),
    .info_table (info_table),
    .uart       (u_if),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int done_cnt = 0;
  int viol_cnt = 0;
  int uart_dly = 1;
  int uart_len = 10;

  // ---------------- UART model ----------------
  logic pend;
  int   dly_left;
  int   bsy_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_if.tx_busy <= 1'b0;
      pend         <= 1'b0;
      dly_left     <= 0;
      bsy_left     <= 0;
    end else if (u_if.tx_start) begin
      pend     <= 1'b1;
      dly_left <= uart_dly;
    end else if (pend) begin
      if (dly_left <= 1) begin
        pend         <= 1'b0;
        u_if.tx_busy <= 1'b1;
        bsy_left     <= uart_len;
      end else begin
        dly_left <= dly_left - 1;
      end
    end else if (u_if.tx_busy) begin
      if (bsy_left <= 1) u_if.tx_busy <= 1'b0;
      else bsy_left <= bsy_left - 1;
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (rst_n && u_if.tx_start) begin
      got_q.push_back(u_if.tx_data);
      if (u_if.tx_busy) viol_cnt <= viol_cnt + 1;
    end
    if (rst_n && done) done_cnt <= done_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // '|' stands for the CR LF line end
  task automatic build_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "|") begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else begin
        exp_q.push_back(8'(s[i]));
      end
    end
  endtask

  function automatic logic [TBL_W-1:0] cls(input int idx, input int cnt);
    return TBL_W'(cnt) << (idx * 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic kick(input logic [5:0] tot, input logic [TBL_W-1:0] tbl,
                      input string name, input bit measure);
    int k;
    @(negedge clk);
    total_count = tot;
    info_table  = tbl;
    start       = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (u_if.tx_start) break;
      if (!measure) break;
    end
    if (measure) check({name, "_latency_le4"}, 32'(k <= 4), 1);
  endtask

  task automatic wait_bytes(input int target, input string name);
    int c;
    c = 0;
    while (got_q.size() < target && c < 4000) begin
      @(negedge clk);
      c++;
    end
    if (got_q.size() < target) check({name, "_byte_timeout"}, got_q.size(), target);
  endtask

  task automatic finish_stream(input string name, input int base, input int d0);
    int c;
    int n;
    c = 0;
    while (done_cnt == d0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (done_cnt == d0) check({name, "_done_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    n = got_q.size() - base;
    check({name, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_byte%0d", name, i), got_q[base + i], exp_q[i]);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_no_start_while_busy"}, viol_cnt, 0);
  endtask

  task automatic run_stream(input logic [5:0] tot, input logic [TBL_W-1:0] tbl,
                            input string exp_s, input string name);
    int base;
    int d0;
    base = got_q.size();
    d0   = done_cnt;
    build_exp(exp_s);
    kick(tot, tbl, name, 1'b1);
    finish_stream(name, base, d0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [5:0]       total;
    logic [TBL_W-1:0] tbl;
    string            exp_s;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base;
    int d0;

    vecs[0] = '{6'd0,  '0,                         "T=0|"};
    vecs[1] = '{6'd2,  cls(7, 2),                  "T=2|2*3*2|"};
    vecs[2] = '{6'd4,  cls(0, 1) | cls(24, 3),     "T=4|1*1*1|5*5*3|"};
    vecs[3] = '{6'd12, cls(5, 1) | cls(13, 2),     "T=12|2*1*1|3*4*2|"};
    vecs[4] = '{6'd63, cls(4, 3) | cls(20, 1),     "T=63|1*5*3|5*1*1|"};
    vecs[5] = '{6'd10, '0,                         "T=10|"};
    vecs[6] = '{6'd9,  cls(12, 2),                 "T=9|3*3*2|"};

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx_start", u_if.tx_start, 0);
    check("rst_tx_data", u_if.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven streams
    for (int v = 0; v < 7; v++)
      run_stream(vecs[v].total, vecs[v].tbl, vecs[v].exp_s, $sformatf("vec%0d", v));

    // handshake stress: slow acceptance, long busy
    uart_dly = 2;
    uart_len = 100;
    run_stream(vecs[2].total, vecs[2].tbl, vecs[2].exp_s, "stress");
    uart_dly = 1;
    uart_len = 10;

    // abort after the third byte
    base = got_q.size();
    d0   = done_cnt;
    kick(vecs[1].total, vecs[1].tbl, "abort", 1'b0);
    wait_bytes(base + 3, "abort");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, 0);
    check("abort_tx_start", u_if.tx_start, 0);
    repeat (200) @(negedge clk);
    check("abort_bytes", got_q.size() - base, 3);
    check("abort_no_done", done_cnt - d0, 0);
    run_stream(vecs[1].total, vecs[1].tbl, vecs[1].exp_s, "after_abort");

    // inputs change mid-print
    base = got_q.size();
    d0   = done_cnt;
    build_exp(vecs[2].exp_s);
    kick(vecs[2].total, vecs[2].tbl, "snap", 1'b0);
    wait_bytes(base + 2, "snap");
    total_count = 6'd33;
    info_table  = {TBL_W{1'b1}};
    finish_stream("snap", base, d0);

    // second start mid-print is ignored
    base = got_q.size();
    d0   = done_cnt;
    build_exp(vecs[3].exp_s);
    kick(vecs[3].total, vecs[3].tbl, "restart", 1'b0);
    wait_bytes(base + 4, "restart");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_stream("restart", base, d0);

    // start and abort together while idle
    base = got_q.size();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("clash_busy", busy, 0);
    check("clash_state", dbg_state, 0);
    repeat (10) @(negedge clk);
    check("clash_bytes", got_q.size() - base, 0);

    // asynchronous reset in the middle of a stream
    base = got_q.size();
    kick(vecs[2].total, vecs[2].tbl, "areset", 1'b0);
    wait_bytes(base + 4, "areset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_tx_start", u_if.tx_start, 0);
    check("areset_tx_data", u_if.tx_data, 0);
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    check("areset_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_stream(vecs[0].total, vecs[0].tbl, vecs[0].exp_s, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
